// File: rtl/ttt_pkg.sv
// ============================================================================
//  Module  : ttt_pkg
//  Purpose : Shared types and constants for the tic-tac-toe board judge:
//            result encodings, the win-line cell table and the scan FSM state.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ttt_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_X    = 2'b01;
    localparam logic [1:0] RES_O    = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    // Cell indices (row*3 + col) of each line, in scan order:
    // rows 0..2, columns 3..5, diagonal 6, anti-diagonal 7.
    localparam logic [3:0] LINE_CELLS [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage : ttt_pkg

`default_nettype wire

// File: rtl/ttt_line_check.sv
// ============================================================================
//  Module  : ttt_line_check
//  Purpose : Combinational test of one three-cell line. A line wins when all
//            three cells are occupied and carry the same symbol.
//  Ports   : valid[2:0]  in  occupied flags of the three cells
//            symbol[2:0] in  symbols of the three cells
//            win         out line is complete for one player
//            owner       out symbol of the winner (meaningful when win=1)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ttt_line_check (
    input  logic [2:0] valid,
    input  logic [2:0] symbol,
    output logic       win,
    output logic       owner
);

    logic w_all_valid;
    logic w_all_same;

    assign w_all_valid = &valid;
    assign w_all_same  = (symbol == 3'b111) || (symbol == 3'b000);
    assign win         = w_all_valid && w_all_same;
    assign owner       = symbol[0];

endmodule : ttt_line_check

`default_nettype wire

// File: rtl/ttt_board_judge.sv
// ============================================================================
//  Module  : ttt_board_judge
//  Purpose : Snapshots the nine tic-tac-toe cells on request and scans the
//            eight win lines one per clock, then reports X win / O win /
//            draw / none with a one-cycle done pulse.
//  Params  : X_SYMBOL    symbol value that denotes player X
//            AUTO_RESCAN 1: in IDLE a live-vs-snapshot difference starts a scan
//  Macro   : TTT_WIN_LINE_EN adds the win_line output and its register
//  Ports   : clk, reset (sync, active high)
//            start          in   scan request, honoured only in IDLE
//            cell_valid[8:0]  in per-cell occupied flag
//            cell_symbol[8:0] in per-cell symbol
//            busy           out  scan in progress
//            done           out  one-cycle pulse, result updated
//            result[1:0]    out  00 none, 01 X, 10 O, 11 draw
//            win_line[2:0]  out  winning line index (TTT_WIN_LINE_EN only)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ttt_board_judge
    import ttt_pkg::*;
#(
    parameter logic X_SYMBOL    = 1'b1,
    parameter int   AUTO_RESCAN = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_CELLS-1:0] cell_valid,
    input  logic [NUM_CELLS-1:0] cell_symbol,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           result
`ifdef TTT_WIN_LINE_EN
    ,
    output logic [2:0]           win_line
`endif
);

    localparam logic [2:0] c_last_line = 3'(NUM_LINES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [NUM_CELLS-1:0] r_snap_valid;
    logic [NUM_CELLS-1:0] r_snap_symbol;
    logic [2:0]           r_ctr;
    logic                 r_found;
    logic                 r_owner;
    logic                 r_done;
    logic [1:0]           r_result;
`ifdef TTT_WIN_LINE_EN
    logic [2:0]           r_win_idx;
    logic [2:0]           r_win_line;
`endif

    logic       w_capture;
    logic       w_finish;
    logic       w_live_diff;
    logic       w_trigger;
    logic [2:0] w_lv;
    logic [2:0] w_ls;
    logic       w_win;
    logic       w_owner;
    logic       w_any_win;
    logic       w_final_owner;

    // Symbols of empty cells are don't-care, so they are masked before
    // comparing the live board against the snapshot.
    assign w_live_diff = (cell_valid != r_snap_valid) ||
                         ((cell_symbol & cell_valid) != (r_snap_symbol & r_snap_valid));
    assign w_trigger   = start || ((AUTO_RESCAN != 0) && w_live_diff);

    // Route the three snapshot cells of the current line to the shared checker.
    always_comb begin
        w_lv = '0;
        w_ls = '0;
        for (int k = 0; k < 3; k++) begin
            w_lv[k] = r_snap_valid[LINE_CELLS[r_ctr][k]];
            w_ls[k] = r_snap_symbol[LINE_CELLS[r_ctr][k]];
        end
    end

    ttt_line_check u_line_check (
        .valid  (w_lv),
        .symbol (w_ls),
        .win    (w_win),
        .owner  (w_owner)
    );

    // The last line is evaluated on the same edge that publishes the result,
    // so a win on it must be folded in combinationally.
    assign w_any_win     = r_found || w_win;
    assign w_final_owner = r_found ? r_owner : w_owner;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_ctr == c_last_line) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_snap_valid  <= '0;
            r_snap_symbol <= '0;
            r_ctr         <= '0;
            r_found       <= 1'b0;
            r_owner       <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= RES_NONE;
`ifdef TTT_WIN_LINE_EN
            r_win_idx     <= '0;
            r_win_line    <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_done  <= w_finish;
            if (w_capture) begin
                r_snap_valid  <= cell_valid;
                r_snap_symbol <= cell_symbol;
                r_ctr         <= '0;
                r_found       <= 1'b0;
            end else if (r_state == ST_SCAN) begin
                r_ctr <= r_ctr + 3'd1;
                // Only the lowest-index winning line is kept.
                if (!r_found && w_win) begin
                    r_found   <= 1'b1;
                    r_owner   <= w_owner;
`ifdef TTT_WIN_LINE_EN
                    r_win_idx <= r_ctr;
`endif
                end
            end
            if (w_finish) begin
                if (w_any_win) begin
                    r_result <= (w_final_owner == X_SYMBOL) ? RES_X : RES_O;
                end else if (&r_snap_valid) begin
                    r_result <= RES_DRAW;
                end else begin
                    r_result <= RES_NONE;
                end
`ifdef TTT_WIN_LINE_EN
                if (r_found) begin
                    r_win_line <= r_win_idx;
                end else if (w_win) begin
                    r_win_line <= r_ctr;
                end else begin
                    r_win_line <= '0;
                end
`endif
            end
        end
    end

    assign busy   = (r_state == ST_SCAN);
    assign done   = r_done;
    assign result = r_result;
`ifdef TTT_WIN_LINE_EN
    assign win_line = r_win_line;
`endif

endmodule : ttt_board_judge

`default_nettype wire

// File: tb/tb_ttt_board_judge.sv
// ============================================================================
//  Module  : tb_ttt_board_judge
//  Purpose : Directed self-checking bench for ttt_board_judge. Instance u_dut
//            uses the default configuration; u_auto has AUTO_RESCAN=1.
//            Define TTT_WIN_LINE_EN to also check win_line.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ttt_board_judge;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] cell_valid;
    logic [8:0] cell_symbol;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic [2:0] win_line;

    logic       a_start;
    logic [8:0] a_valid;
    logic [8:0] a_symbol;
    logic       a_busy;
    logic       a_done;
    logic [1:0] a_result;
    logic [2:0] a_win_line;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ttt_board_judge #(
        .X_SYMBOL    (1'b1),
        .AUTO_RESCAN (0)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cell_valid  (cell_valid),
        .cell_symbol (cell_symbol),
        .busy        (busy),
        .done        (done),
        .result      (result)
`ifdef TTT_WIN_LINE_EN
        ,
        .win_line    (win_line)
`endif
    );

    ttt_board_judge #(
        .X_SYMBOL    (1'b1),
        .AUTO_RESCAN (1)
    ) u_auto (
        .clk         (clk),
        .reset       (reset),
        .start       (a_start),
        .cell_valid  (a_valid),
        .cell_symbol (a_symbol),
        .busy        (a_busy),
        .done        (a_done),
        .result      (a_result)
`ifdef TTT_WIN_LINE_EN
        ,
        .win_line    (a_win_line)
`endif
    );

`ifndef TTT_WIN_LINE_EN
    assign win_line   = 3'd0;
    assign a_win_line = 3'd0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a scan on the given board and check busy/done cycle by cycle;
    // returns in the done cycle, so a following call starts back-to-back.
    task automatic run_scan(input string tag, input logic [8:0] v, input logic [8:0] s,
                            input logic [1:0] exp_res, input logic [2:0] exp_line);
        cell_valid  = v;
        cell_symbol = s;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, " busy"}, busy, 1'b1);
            chk({tag, " done_early"}, done, 1'b0);
            tick();
        end
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " busy_end"}, busy, 1'b0);
        chk({tag, " result"}, result, exp_res);
`ifdef TTT_WIN_LINE_EN
        chk({tag, " win_line"}, win_line, exp_line);
`else
        if (exp_line != exp_line) chk({tag, " unused"}, 0, 0);
`endif
    endtask

    initial begin
        int seen_done;
        reset       = 1'b1;
        start       = 1'b0;
        cell_valid  = '0;
        cell_symbol = '0;
        a_start     = 1'b0;
        a_valid     = '0;
        a_symbol    = '0;
        tick();
        tick();
        reset = 1'b0;

        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 2'b00);
`ifdef TTT_WIN_LINE_EN
        chk("reset win_line", win_line, 3'd0);
`endif

        // Back-to-back scans over a set of boards.
        run_scan("empty",     9'h000, 9'h000, 2'b00, 3'd0);
        run_scan("x_anti",    9'h054, 9'h054, 2'b01, 3'd7);
        run_scan("o_col1",    9'h097, 9'h005, 2'b10, 3'd4);
        run_scan("draw",      9'h1FF, 9'h163, 2'b11, 3'd0);
        run_scan("x_2rows",   9'h03F, 9'h03F, 2'b01, 3'd0);
        run_scan("partial",   9'h011, 9'h001, 2'b00, 3'd0);
        run_scan("o_diag",    9'h111, 9'h000, 2'b10, 3'd6);
        tick();
        chk("idle after scan busy", busy, 1'b0);
        chk("idle after scan done", done, 1'b0);
        chk("result held", result, 2'b10);

        // Mid-scan cell change plus extra start: result from first snapshot.
        cell_valid  = 9'h054;
        cell_symbol = 9'h054;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("midchg busy", busy, 1'b1);
            chk("midchg done_early", done, 1'b0);
            if (i == 3) begin
                cell_valid  = 9'h007;
                cell_symbol = 9'h000;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("midchg done", done, 1'b1);
        chk("midchg result", result, 2'b01);
`ifdef TTT_WIN_LINE_EN
        chk("midchg win_line", win_line, 3'd7);
`endif
        tick();
        chk("midchg not queued busy", busy, 1'b0);
        chk("midchg done drops", done, 1'b0);

        // Reset in the fourth scan cycle aborts the scan without done.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_reset busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort result", result, 2'b00);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) seen_done++;
            tick();
        end
        chk("abort no activity", seen_done, 0);

        // Self-starting scan: AUTO_RESCAN instance idles on an unchanged board.
        chk("auto idle busy", a_busy, 1'b0);
        a_valid  = 9'h001;
        a_symbol = 9'h001;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("auto busy", a_busy, 1'b1);
            chk("auto done_early", a_done, 1'b0);
            tick();
        end
        chk("auto done", a_done, 1'b1);
        chk("auto result", a_result, 2'b00);
        tick();
        chk("auto settles", a_busy, 1'b0);
        chk("main unaffected", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ttt_board_judge

`default_nettype wire
